// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   lsu_size_e  : access size encoding (3 is illegal and has no member)
//   lsu_state_e : control FSM states
//   lsu_strobe  : byte-lane mask of nb bytes starting at lane off
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Wide enough for the two-beat mask of the 128-bit bus (2*16 lanes).
  localparam int unsigned STRB_W = 32;

  function automatic logic [STRB_W-1:0] lsu_strobe(input logic [4:0] off,
                                                   input logic [3:0] nb);
    logic [STRB_W-1:0] ones;
    ones = (STRB_W'(1) << nb) - STRB_W'(1);
    return ones << off;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane alignment for the load/store unit.
//   off_i      : byte offset of the access within one bus beat
//   size_i     : access size (lsu_size_e encoding)
//   unsigned_i : zero-extend load data instead of sign-extending
//   wdata_i    : right-aligned store data
//   rbuf_i     : two-beat read buffer (beat0 in the low half)
//   wvec_o     : two-beat store data vector, shifted into its lanes
//   strb_o     : two-beat store strobe vector
//   rdata_o    : extracted and extended load result
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned NB        = DATA_WIDTH / 8,
  localparam int unsigned OFF_W     = $clog2(NB)
) (
  input  logic [OFF_W-1:0]        off_i,
  input  logic [1:0]              size_i,
  input  logic                    unsigned_i,
  input  logic [31:0]             wdata_i,
  input  logic [2*DATA_WIDTH-1:0] rbuf_i,
  output logic [2*DATA_WIDTH-1:0] wvec_o,
  output logic [2*NB-1:0]         strb_o,
  output logic [31:0]             rdata_o
);

  logic [3:0]  nb;
  logic [31:0] rword;

  always_comb begin
    nb      = 4'd1 << size_i;
    wvec_o  = {{(2*DATA_WIDTH-32){1'b0}}, wdata_i} << {off_i, 3'b000};
    strb_o  = (2*NB)'(lsu_strobe(5'(off_i), nb));
    rword   = 32'(rbuf_i >> {off_i, 3'b000});
    case (lsu_size_e'(size_i))
      SZ_B:    rdata_o = {{24{rword[7]  & ~unsigned_i}}, rword[7:0]};
      SZ_H:    rdata_o = {{16{rword[15] & ~unsigned_i}}, rword[15:0]};
      default: rdata_o = rword;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit: one request at a time, split of lane-crossing
// accesses into two bus beats, load extension, one response per request.
//   i_req_*  / o_req_ready : request handshake from execute
//   o_rsp_*  / i_rsp_ready : response handshake (rdata, fault)
//   o_addr, o_data, o_wr_valid, i_wr_ready, o_byte_write_enable : write beat
//   i_data, i_rd_valid, o_rd_ready                            : read beat
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_store,
  input  logic [1:0]              i_req_size,
  input  logic                    i_req_unsigned,
  input  logic [31:0]             i_req_addr,
  input  logic [31:0]             i_req_wdata,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [31:0]             o_rsp_rdata,
  output logic                    o_rsp_fault,
  output logic [31:0]             o_addr,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_wr_valid,
  input  logic                    i_wr_ready,
  output logic [DATA_WIDTH/8-1:0] o_byte_write_enable,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_rd_valid,
  output logic                    o_rd_ready
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  lsu_state_e              state_q, state_d;
  logic                    store_q, store_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    cross_q, cross_d;
  logic                    fault_q, fault_d;
  logic [2*DATA_WIDTH-1:0] rbuf_q, rbuf_d;

  logic [2*DATA_WIDTH-1:0] wvec;
  logic [2*NB-1:0]         strb;
  logic [31:0]             rdata;
  logic [31:0]             base;
  logic [3:0]              acc_nb;
  logic [4:0]              acc_end;
  logic                    acc_cross;
  logic                    hs;

  lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .off_i      (addr_q[OFF_W-1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rbuf_i     (rbuf_q),
    .wvec_o     (wvec),
    .strb_o     (strb),
    .rdata_o    (rdata)
  );

  always_comb begin
    base      = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
    acc_nb    = 4'd1 << i_req_size;
    acc_end   = 5'(i_req_addr[OFF_W-1:0]) + 5'(acc_nb);
    acc_cross = acc_end > 5'(NB);
  end

  always_comb begin
    state_d             = state_q;
    store_d             = store_q;
    size_d              = size_q;
    uns_d               = uns_q;
    addr_d              = addr_q;
    wdata_d             = wdata_q;
    cross_d             = cross_q;
    fault_d             = fault_q;
    rbuf_d              = rbuf_q;
    hs                  = 1'b0;
    o_req_ready         = 1'b0;
    o_rsp_valid         = 1'b0;
    o_rsp_rdata         = '0;
    o_rsp_fault         = 1'b0;
    o_addr              = '0;
    o_data              = '0;
    o_wr_valid          = 1'b0;
    o_byte_write_enable = '0;
    o_rd_ready          = 1'b0;

    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          store_d = i_req_store;
          size_d  = i_req_size;
          uns_d   = i_req_unsigned;
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          cross_d = acc_cross;
          fault_d = (i_req_size == 2'd3) || (!ALLOW_MISALIGNED && acc_cross);
          state_d = ((i_req_size == 2'd3) || (!ALLOW_MISALIGNED && acc_cross))
                    ? RESP : BEAT0;
        end
      end
      BEAT0: begin
        o_addr = base;
        if (store_q) begin
          o_wr_valid          = 1'b1;
          o_data              = wvec[DATA_WIDTH-1:0];
          o_byte_write_enable = strb[NB-1:0];
          hs                  = i_wr_ready;
        end else begin
          o_rd_ready = 1'b1;
          hs         = i_rd_valid;
        end
        if (hs) begin
          if (!store_q) rbuf_d[DATA_WIDTH-1:0] = i_data;
          state_d = cross_q ? BEAT1 : RESP;
        end
      end
      BEAT1: begin
        o_addr = base + 32'(NB);
        if (store_q) begin
          o_wr_valid          = 1'b1;
          o_data              = wvec[2*DATA_WIDTH-1:DATA_WIDTH];
          o_byte_write_enable = strb[2*NB-1:NB];
          hs                  = i_wr_ready;
        end else begin
          o_rd_ready = 1'b1;
          hs         = i_rd_valid;
        end
        if (hs) begin
          if (!store_q) rbuf_d[2*DATA_WIDTH-1:DATA_WIDTH] = i_data;
          state_d = RESP;
        end
      end
      default: begin
        o_rsp_valid = 1'b1;
        o_rsp_fault = fault_q;
        o_rsp_rdata = (store_q || fault_q) ? '0 : rdata;
        if (i_rsp_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cross_q <= 1'b0;
      fault_q <= 1'b0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cross_q <= cross_d;
      fault_q <= fault_d;
      rbuf_q  <= rbuf_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        wr_ready = 1'b1;
  logic        rd_valid = 1'b1;
  logic        rsp_ready = 1'b1;
  logic [31:0] data32 = '0;
  logic [63:0] data64 = '0;
  logic        va = 1'b0, vb = 1'b0, vc = 1'b0;

  logic        a_req_ready, a_rsp_valid, a_rsp_fault, a_wr_valid, a_rd_ready;
  logic [31:0] a_rsp_rdata, a_addr, a_data;
  logic [3:0]  a_be;
  logic        b_req_ready, b_rsp_valid, b_rsp_fault, b_wr_valid, b_rd_ready;
  logic [31:0] b_rsp_rdata, b_addr, b_data;
  logic [3:0]  b_be;
  logic        c_req_ready, c_rsp_valid, c_rsp_fault, c_wr_valid, c_rd_ready;
  logic [31:0] c_rsp_rdata, c_addr;
  logic [63:0] c_data;
  logic [7:0]  c_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(va), .o_req_ready(a_req_ready),
    .i_req_store(req_store), .i_req_size(req_size), .i_req_unsigned(req_uns),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_rsp_valid(a_rsp_valid),
    .i_rsp_ready(rsp_ready), .o_rsp_rdata(a_rsp_rdata), .o_rsp_fault(a_rsp_fault),
    .o_addr(a_addr), .o_data(a_data), .o_wr_valid(a_wr_valid), .i_wr_ready(wr_ready),
    .o_byte_write_enable(a_be), .i_data(data32), .i_rd_valid(rd_valid),
    .o_rd_ready(a_rd_ready));

  load_store_unit #(.DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(vb), .o_req_ready(b_req_ready),
    .i_req_store(req_store), .i_req_size(req_size), .i_req_unsigned(req_uns),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_rsp_valid(b_rsp_valid),
    .i_rsp_ready(rsp_ready), .o_rsp_rdata(b_rsp_rdata), .o_rsp_fault(b_rsp_fault),
    .o_addr(b_addr), .o_data(b_data), .o_wr_valid(b_wr_valid), .i_wr_ready(wr_ready),
    .o_byte_write_enable(b_be), .i_data(data32), .i_rd_valid(rd_valid),
    .o_rd_ready(b_rd_ready));

  load_store_unit #(.DATA_WIDTH(64), .ALLOW_MISALIGNED(1'b1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(vc), .o_req_ready(c_req_ready),
    .i_req_store(req_store), .i_req_size(req_size), .i_req_unsigned(req_uns),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_rsp_valid(c_rsp_valid),
    .i_rsp_ready(rsp_ready), .o_rsp_rdata(c_rsp_rdata), .o_rsp_fault(c_rsp_fault),
    .o_addr(c_addr), .o_data(c_data), .o_wr_valid(c_wr_valid), .i_wr_ready(wr_ready),
    .o_byte_write_enable(c_be), .i_data(data64), .i_rd_valid(rd_valid),
    .o_rd_ready(c_rd_ready));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic st, input logic [1:0] sz, input logic un,
                     input logic [31:0] ad, input logic [31:0] wd);
    req_store = st; req_size = sz; req_uns = un; req_addr = ad; req_wdata = wd;
  endtask

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", a_req_ready, 1);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_wr_valid",  a_wr_valid, 0);
    chk("rst_rd_ready",  a_rd_ready, 0);
    chk("rst_addr",      a_addr, 0);
    chk("rst_c_be",      c_be, 0);
    #9 rst_n = 1'b1;

    // SW 0xDEADBEEF @0x100
    req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF); va = 1'b1;
    tick(); va = 1'b0;
    chk("sw_wr_valid", a_wr_valid, 1);
    chk("sw_addr", a_addr, 32'h100);
    chk("sw_be", a_be, 4'hF);
    chk("sw_data", a_data, 32'hDEADBEEF);
    chk("sw_req_ready_busy", a_req_ready, 0);
    chk("sw_rsp_early", a_rsp_valid, 0);
    tick();
    chk("sw_rsp_valid", a_rsp_valid, 1);
    chk("sw_rsp_rdata", a_rsp_rdata, 0);
    chk("sw_rsp_fault", a_rsp_fault, 0);
    chk("sw_wr_done", a_wr_valid, 0);
    tick();
    chk("sw_idle", a_req_ready, 1);

    // LB @0x103 -> sign extended
    req(1'b0, 2'd0, 1'b0, 32'h103, 0); va = 1'b1; data32 = 32'h80000000;
    tick(); va = 1'b0;
    chk("lb_rd_ready", a_rd_ready, 1);
    chk("lb_addr", a_addr, 32'h100);
    chk("lb_wr_valid", a_wr_valid, 0);
    tick();
    chk("lb_rdata", a_rsp_rdata, 32'hFFFFFF80);
    tick();
    // LBU same access
    req(1'b0, 2'd0, 1'b1, 32'h103, 0); va = 1'b1;
    tick(); va = 1'b0;
    tick();
    chk("lbu_rdata", a_rsp_rdata, 32'h00000080);
    tick();

    // Split LW @0x102
    req(1'b0, 2'd2, 1'b0, 32'h102, 0); va = 1'b1; data32 = 32'h44332211;
    tick(); va = 1'b0;
    chk("slw_b0_addr", a_addr, 32'h100);
    chk("slw_b0_rd", a_rd_ready, 1);
    tick(); data32 = 32'h88776655;
    chk("slw_b1_addr", a_addr, 32'h104);
    chk("slw_b1_rd", a_rd_ready, 1);
    chk("slw_b1_norsp", a_rsp_valid, 0);
    tick();
    chk("slw_rsp_valid", a_rsp_valid, 1);
    chk("slw_rdata", a_rsp_rdata, 32'h66554433);
    tick();

    // Split LW wrapping the address space
    req(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 0); va = 1'b1;
    tick(); va = 1'b0;
    chk("wrap_b0_addr", a_addr, 32'hFFFFFFFC);
    tick();
    chk("wrap_b1_addr", a_addr, 32'h00000000);
    tick();
    tick();

    // Split SH 0xAABB @0x103
    req(1'b1, 2'd1, 1'b0, 32'h103, 32'h0000AABB); va = 1'b1;
    tick(); va = 1'b0;
    chk("sh_b0_addr", a_addr, 32'h100);
    chk("sh_b0_be", a_be, 4'b1000);
    chk("sh_b0_byte3", a_data[31:24], 8'hBB);
    tick();
    chk("sh_b1_addr", a_addr, 32'h104);
    chk("sh_b1_be", a_be, 4'b0001);
    chk("sh_b1_byte0", a_data[7:0], 8'hAA);
    tick();
    chk("sh_rsp_rdata", a_rsp_rdata, 0);
    tick();

    // Misaligned fault when splitting is disabled
    req(1'b0, 2'd2, 1'b0, 32'h102, 0); vb = 1'b1;
    tick(); vb = 1'b0;
    chk("mis_rsp_valid", b_rsp_valid, 1);
    chk("mis_fault", b_rsp_fault, 1);
    chk("mis_rdata", b_rsp_rdata, 0);
    chk("mis_rd_ready", b_rd_ready, 0);
    tick();
    chk("mis_idle", b_req_ready, 1);
    // Illegal size
    req(1'b0, 2'd3, 1'b0, 32'h100, 0); vb = 1'b1;
    tick(); vb = 1'b0;
    chk("sz3_rsp_valid", b_rsp_valid, 1);
    chk("sz3_fault", b_rsp_fault, 1);
    chk("sz3_rdata", b_rsp_rdata, 0);
    chk("sz3_rd_ready", b_rd_ready, 0);
    tick();
    // Aligned LW on the non-splitting unit still works
    req(1'b0, 2'd2, 1'b0, 32'h200, 0); vb = 1'b1; data32 = 32'h01020304;
    tick(); vb = 1'b0;
    chk("b_lw_rd_ready", b_rd_ready, 1);
    tick();
    chk("b_lw_fault", b_rsp_fault, 0);
    chk("b_lw_rdata", b_rsp_rdata, 32'h01020304);
    tick();

    // 64-bit bus: SW @0x0C with write wait states, then response back-pressure
    wr_ready = 1'b0;
    req(1'b1, 2'd2, 1'b0, 32'h0C, 32'h12345678); vc = 1'b1;
    tick(); vc = 1'b0;
    req(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    chk("w64_addr", c_addr, 32'h08);
    chk("w64_be", c_be, 8'hF0);
    chk("w64_data", c_data, 64'h12345678_00000000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("w64_hold_valid", c_wr_valid, 1);
      chk("w64_hold_addr", c_addr, 32'h08);
      chk("w64_hold_be", c_be, 8'hF0);
      chk("w64_hold_data", c_data, 64'h12345678_00000000);
      chk("w64_hold_norsp", c_rsp_valid, 0);
    end
    wr_ready = 1'b1; rsp_ready = 1'b0;
    tick();
    chk("w64_rsp_valid", c_rsp_valid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w64_rsp_hold", c_rsp_valid, 1);
      chk("w64_rsp_rdata", c_rsp_rdata, 0);
      chk("w64_rsp_notready", c_req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("w64_idle", c_req_ready, 1);
    chk("w64_rsp_done", c_rsp_valid, 0);

    // 64-bit bus: reset asserted during BEAT1 of a split LW @0x06
    req(1'b0, 2'd2, 1'b0, 32'h06, 0); vc = 1'b1; data64 = 64'h1122334455667788;
    tick(); vc = 1'b0;
    chk("r64_b0_addr", c_addr, 32'h00);
    tick();
    chk("r64_b1_addr", c_addr, 32'h08);
    chk("r64_b1_rd", c_rd_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r64_rst_rd", c_rd_ready, 0);
    chk("r64_rst_addr", c_addr, 0);
    chk("r64_rst_rsp", c_rsp_valid, 0);
    chk("r64_rst_req_ready", c_req_ready, 1);
    #2 rst_n = 1'b1;
    tick();
    chk("r64_after_idle", c_req_ready, 1);
    chk("r64_after_rd", c_rd_ready, 0);
    chk("r64_after_rsp", c_rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
